// File: rtl/pc_stack_ctrl_pkg.sv
// pc_stack_ctrl_pkg: shared state, fault-code and stack-op encodings for the PC/return-stack sequencer.
package pc_stack_ctrl_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_STK, ST_FAULT} state_e;
    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;
    localparam logic [1:0] FC_ILL  = 2'b11;
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;
endpackage

// File: rtl/pc_stack_ctrl.sv
// pc_stack_ctrl: owns the PC and turns CALL/RET/JUMP requests into push/pop strobes on the return stack.
module pc_stack_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              call,
    input  logic              ret,
    input  logic              jump,
    input  logic [ADDR_W-1:0] target_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              stack_en,
    output logic              stack_push_pop,
    output logic [ADDR_W-1:0] stack_data_in,
    input  logic [ADDR_W-1:0] stack_data_out,
    output logic              fault,
    output logic [1:0]        fault_code
);
    import pc_stack_ctrl_pkg::*;

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, din_q, din_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              busy_q, busy_d, en_q, en_d, pp_q, pp_d, fault_q, fault_d;
    logic [1:0]        code_q, code_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        din_d   = din_q;
        depth_d = depth_q;
        busy_d  = busy_q;
        en_d    = 1'b0;
        pp_d    = pp_q;
        fault_d = fault_q;
        code_d  = code_q;
        case (state_q)
            ST_RUN: if (!stall) begin
                if (call && ret) begin
                    state_d = ST_FAULT;
                    busy_d  = 1'b1;
                    fault_d = 1'b1;
                    code_d  = FC_ILL;
                end else if (call) begin
                    if (depth_q == DEPTH_MAX) begin
                        state_d = ST_FAULT;
                        busy_d  = 1'b1;
                        fault_d = 1'b1;
                        code_d  = FC_OVF;
                    end else begin
                        state_d = ST_STK;
                        pc_d    = target_addr;
                        din_d   = pc_q + ADDR_W'(1);
                        en_d    = 1'b1;
                        pp_d    = OP_PUSH;
                        depth_d = depth_q + DW'(1);
                        busy_d  = 1'b1;
                    end
                end else if (ret) begin
                    if (depth_q == '0) begin
                        state_d = ST_FAULT;
                        busy_d  = 1'b1;
                        fault_d = 1'b1;
                        code_d  = FC_UNF;
                    end else begin
                        // Top-of-stack is combinational, so the return address is taken this cycle.
                        state_d = ST_STK;
                        pc_d    = stack_data_out;
                        en_d    = 1'b1;
                        pp_d    = OP_POP;
                        depth_d = depth_q - DW'(1);
                        busy_d  = 1'b1;
                    end
                end else begin
                    pc_d = jump ? target_addr : pc_q + ADDR_W'(1);
                end
            end
            ST_STK: begin
                state_d = ST_RUN;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            din_q   <= '0;
            depth_q <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            pp_q    <= OP_PUSH;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            din_q   <= din_d;
            depth_q <= depth_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            pp_q    <= pp_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign pc             = pc_q;
    assign busy           = busy_q;
    assign stack_en       = en_q;
    assign stack_push_pop = pp_q;
    assign stack_data_in  = din_q;
    assign fault          = fault_q;
    assign fault_code     = code_q;
endmodule

// File: tb/tb_pc_stack_ctrl.sv
// tb_pc_stack_ctrl: directed scoreboard bench; stimulus queues expected outputs, a monitor compares after each edge.
module tb_pc_stack_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, call = 1'b0, ret = 1'b0, jump = 1'b0;
    logic [11:0] target_addr = '0, stack_data_out = '0;
    logic [11:0] pc, stack_data_in;
    logic        busy, stack_en, stack_push_pop, fault;
    logic [1:0]  fault_code;

    typedef struct {
        string       name;
        logic [29:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    pc_stack_ctrl #(.ADDR_W(12), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .call(call), .ret(ret), .jump(jump),
        .target_addr(target_addr), .pc(pc), .busy(busy), .stack_en(stack_en),
        .stack_push_pop(stack_push_pop), .stack_data_in(stack_data_in),
        .stack_data_out(stack_data_out), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] dut_vec();
        return {pc, stack_en, stack_push_pop, stack_data_in, busy, fault, fault_code};
    endfunction

    task automatic chk(input string n, input logic [29:0] got, input logic [29:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s got pc=%h en=%b pp=%b din=%h busy=%b fault=%b code=%b want pc=%h en=%b pp=%b din=%h busy=%b fault=%b code=%b",
            n, got[29:18], got[17], got[16], got[15:4], got[3], got[2], got[1:0],
            want[29:18], want[17], want[16], want[15:4], want[3], want[2], want[1:0]);
    endtask

    // Drive one cycle of requests and queue the outputs expected after the next posedge.
    task automatic st(input string n, input logic c, r, j, s, input logic [11:0] tgt, sdo, e_pc,
                      input logic e_en, e_pp, input logic [11:0] e_din, input logic e_b, e_f,
                      input logic [1:0] e_fc);
        exp_t e;
        call = c; ret = r; jump = j; stall = s; target_addr = tgt; stack_data_out = sdo;
        e.name = n;
        e.v = {e_pc, e_en, e_pp, e_din, e_b, e_f, e_fc};
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset(input string n);
        reset = 1'b0;
        call = 0; ret = 0; jump = 0; stall = 0; target_addr = '0; stack_data_out = '0;
        #1 chk(n, dut_vec(), 30'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, dut_vec(), e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        do_reset("reset0");
        for (int i = 1; i <= 16; i++) st("inc", 0,0,0,0, 12'h0, 12'h0, 12'(i), 0,0, 12'h000, 0,0, 2'b00);
        st("call",     1,0,0,0, 12'h200, 12'h0,   12'h200, 1,0, 12'h011, 1,0, 2'b00);
        st("call_stk", 0,0,0,0, 12'h0,   12'h0,   12'h200, 0,0, 12'h011, 0,0, 2'b00);
        st("run1",     0,0,0,0, 12'h0,   12'h0,   12'h201, 0,0, 12'h011, 0,0, 2'b00);
        st("run2",     0,0,0,0, 12'h0,   12'h0,   12'h202, 0,0, 12'h011, 0,0, 2'b00);
        st("run3",     0,0,0,0, 12'h0,   12'h0,   12'h203, 0,0, 12'h011, 0,0, 2'b00);
        st("ret",      0,1,0,0, 12'h0,   12'h011, 12'h011, 1,1, 12'h011, 1,0, 2'b00);
        st("ret_stk",  0,0,0,0, 12'h0,   12'h0,   12'h011, 0,1, 12'h011, 0,0, 2'b00);
        st("jump",     0,0,1,0, 12'hFFE, 12'h0,   12'hFFE, 0,1, 12'h011, 0,0, 2'b00);
        st("inc_fff",  0,0,0,0, 12'h0,   12'h0,   12'hFFF, 0,1, 12'h011, 0,0, 2'b00);
        st("wrap",     0,0,0,0, 12'h0,   12'h0,   12'h000, 0,1, 12'h011, 0,0, 2'b00);
        st("unf",      0,1,0,0, 12'h0,   12'h123, 12'h000, 0,1, 12'h011, 1,1, 2'b10);
        st("unf_hold", 1,0,0,0, 12'h555, 12'h0,   12'h000, 0,1, 12'h011, 1,1, 2'b10);
        do_reset("reset1");
        st("ill",      1,1,0,0, 12'h300, 12'h0AA, 12'h000, 0,0, 12'h000, 1,1, 2'b11);
        st("ill_hold", 0,0,1,0, 12'h300, 12'h0,   12'h000, 0,0, 12'h000, 1,1, 2'b11);
        do_reset("reset2");
        st("stall1",   1,0,0,1, 12'h700, 12'h0,   12'h000, 0,0, 12'h000, 0,0, 2'b00);
        st("stall2",   0,0,1,1, 12'h700, 12'h0,   12'h000, 0,0, 12'h000, 0,0, 2'b00);
        st("c1",       1,0,0,0, 12'h100, 12'h0,   12'h100, 1,0, 12'h001, 1,0, 2'b00);
        st("c1_stk",   0,0,0,0, 12'h0,   12'h0,   12'h100, 0,0, 12'h001, 0,0, 2'b00);
        st("c2",       1,0,0,0, 12'h200, 12'h0,   12'h200, 1,0, 12'h101, 1,0, 2'b00);
        st("c2_stk",   0,0,0,0, 12'h0,   12'h0,   12'h200, 0,0, 12'h101, 0,0, 2'b00);
        st("r1",       0,1,0,0, 12'h0,   12'h101, 12'h101, 1,1, 12'h101, 1,0, 2'b00);
        st("r_busy",   0,1,0,0, 12'h0,   12'h001, 12'h101, 0,1, 12'h101, 0,0, 2'b00);
        st("r2",       0,1,0,0, 12'h0,   12'h001, 12'h001, 1,1, 12'h101, 1,0, 2'b00);
        st("r2_stk",   0,0,0,0, 12'h0,   12'h0,   12'h001, 0,1, 12'h101, 0,0, 2'b00);
        st("n1",       1,0,0,0, 12'h100, 12'h0,   12'h100, 1,0, 12'h002, 1,0, 2'b00);
        st("n1_stk",   0,0,0,0, 12'h0,   12'h0,   12'h100, 0,0, 12'h002, 0,0, 2'b00);
        st("n2",       1,0,0,0, 12'h200, 12'h0,   12'h200, 1,0, 12'h101, 1,0, 2'b00);
        st("n2_stk",   0,0,0,0, 12'h0,   12'h0,   12'h200, 0,0, 12'h101, 0,0, 2'b00);
        st("n3",       1,0,0,0, 12'h300, 12'h0,   12'h300, 1,0, 12'h201, 1,0, 2'b00);
        st("n3_stk",   0,0,0,0, 12'h0,   12'h0,   12'h300, 0,0, 12'h201, 0,0, 2'b00);
        st("n4",       1,0,0,0, 12'h400, 12'h0,   12'h400, 1,0, 12'h301, 1,0, 2'b00);
        st("n4_stk",   0,0,0,0, 12'h0,   12'h0,   12'h400, 0,0, 12'h301, 0,0, 2'b00);
        st("ovf",      1,0,0,0, 12'h500, 12'h0,   12'h400, 0,0, 12'h301, 1,1, 2'b01);
        st("ovf_hold", 0,0,0,0, 12'h0,   12'h0,   12'h400, 0,0, 12'h301, 1,1, 2'b01);
        do_reset("reset3");
        st("c_rst",    1,0,0,0, 12'h0AB, 12'h0,   12'h0AB, 1,0, 12'h001, 1,0, 2'b00);
        do_reset("reset_stk");
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain got %0d pending want 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
